multicycle_ctrl_unit: RTL and testbench
=======================================

Name: multicycle_ctrl_unit

Overview:
- Parametrised multicycle control FSM that drives the datapath control bundle: pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl.
- Decodes an RV32I-style subset from the fetched instruction and sequences FETCH, DECODE, EXEC, MEM and WB.
- Adds a memory-wait handshake, an instruction-retired counter and halt handling.
- Sits between instruction memory and the datapath; replaces hand-driven control vectors.

Parameters:
XLEN, 32, instruction width; decode uses bits [31:0] only.
ALUOP_W, 4, aluop width.
STATUS_W, 5, datapath status width; only bits [3:0] are used.
CNT_W, 16, instret counter width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
instr  input  XLEN  instruction word from instruction memory
status  input  STATUS_W  ALU flags: [0]=Z, [1]=N, [2]=C, [3]=V, [4]=reserved
mem_wait  input  1  data memory not ready
pcsrc  output  1  0=pc+4, 1=branch target
alusrc  output  1  1=immediate operand, 0=register operand
aluop  output  ALUOP_W  0000 ADD, 0001 XOR, 0010 AND, 0011 OR, 0100 NOR, 0101 SL, 0110 SR, 0111 SUB
memrw  output  1  1=data memory write
wb  output  1  1=writeback from memory, 0=writeback from ALU
regrw  output  1  register file write enable
immgen_ctrl  output  2  00 I-type, 01 S-type, 10 B-type, 11 unused
ir_load  output  1  latch instr into IR
pc_write  output  1  update PC
state_o  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
halted  output  1  FSM is in HALT
instret  output  CNT_W  retired instruction count

Behaviour:
- Reset: synchronous, active-high, on clk only. State goes to FETCH; IR, instret and all outputs are 0. While rst=1, every output is forced to 0. Reset mid-instruction aborts the instruction with no pc_write and no regrw.
- Outputs are Moore: decoded from the registered state and the latched IR.
- FETCH: ir_load=1, IR<=instr. Next state is DECODE.
- DECODE: all controls 0. Next state from opcode IR[6:0]:
  - 0110011 R-type, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 branch: go to EXEC.
  - 1110011 ECALL: go to HALT.
  - Anything else is illegal; see Optional Feature.
- EXEC: aluop, alusrc and immgen_ctrl are set here and held through MEM and WB.
  - funct3 000 gives ADD, or SUB when R-type and IR[30]=1.
  - funct3 100 XOR, 111 AND, 110 OR, 001 SL, 101 SR; any other funct3 is illegal.
  - alusrc=1 for I-ALU, LW and SW. immgen_ctrl is 00 for I-ALU and LW, 01 for SW, 10 for branch.
  - Branch: aluop=SUB, alusrc=0, pc_write=1.
    - pcsrc=1 when taken: BEQ(000) on Z, BNE(001) on !Z, BLT(100) on N^V, BGE(101) on !(N^V).
    - Other branch funct3 values are illegal.
    - Branch then goes to FETCH.
  - LW and SW go to MEM; R-type and I-ALU go to WB.
- MEM: memrw=1 for SW. The state holds while mem_wait=1, with outputs stable.
  - When mem_wait=0: SW asserts pc_write and goes to FETCH; LW goes to WB.
- WB: regrw=1 and pc_write=1 (pcsrc=0). wb=1 for LW, else 0. Next state is FETCH.
- Latency in cycles: R/I = 4, LW = 5 + wait cycles, SW = 4 + wait cycles, branch = 3.
- instret increments in every cycle where pc_write=1 and wraps from 2^CNT_W-1 to 0.
- HALT: all controls are 0 and halted=1. The FSM stays in HALT until rst; instret is frozen.
- pc_write and regrw are never asserted in the same cycle as ir_load.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode, funct3 or R-type funct7 sends the FSM to HALT from DECODE. An output illegal (1 bit, reset 0) is set and sticks until rst.
- Undefined: illegal instructions retire as NOP: DECODE, then a WB cycle with regrw=0 and pc_write=1, then FETCH. instret increments, and the illegal port is absent.

Test Plan:
- rst held 3 cycles mid-EXEC of an ADD -> next cycle state_o=0, instret=0, no regrw pulse.
- R-type SUB (funct7[5]=1, funct3=000), then I-type XORI -> aluop 0111 then 0001; alusrc 0 then 1; regrw in cycles 4 and 8; instret=2.
- LW with mem_wait=1 for 3 cycles -> MEM held 3 cycles with outputs stable; then WB with wb=1 and regrw=1; 8 cycles total.
- BEQ with status=5'b00001 -> EXEC shows pcsrc=1 and pc_write=1; BEQ with status=0 -> pcsrc=0; each takes 3 cycles.
- Opcode 1111111 -> with ILLEGAL_TRAP_EN: halted=1, illegal=1, instret unchanged. Without it: NOP retires and instret+1.
- CNT_W=4, 16 ADDs -> instret wraps to 0; a following ECALL -> halted=1 and state_o=5 held for 10 cycles.

Source files
------------

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle control FSM: decodes an RV32I subset from the latched IR and sequences FETCH/DECODE/EXEC/MEM/WB.
// Latency: R/I 4 cycles, LW 5 + wait, SW 4 + wait, branch 3; outputs are decoded from registered state and IR.
// Backpressure: mem_wait holds the FSM in MEM with stable outputs; optional ILLEGAL_TRAP_EN halts on illegal instructions.
module multicycle_ctrl_unit #(
  parameter int XLEN     = 32,
  parameter int ALUOP_W  = 4,
  parameter int STATUS_W = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     instr,
  input  logic [STATUS_W-1:0] status,
  input  logic                mem_wait,
  output logic                pcsrc,
  output logic                alusrc,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                memrw,
  output logic                wb,
  output logic                regrw,
  output logic [1:0]          immgen_ctrl,
  output logic                ir_load,
  output logic                pc_write,
  output logic [2:0]          state_o,
  output logic                halted,
  output logic [CNT_W-1:0]    instret
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                illegal
`endif
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4'b0011);
  localparam logic [ALUOP_W-1:0] ALU_SL  = ALUOP_W'(4'b0101);
  localparam logic [ALUOP_W-1:0] ALU_SR  = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4'b0111);

  state_t      state;
  logic [31:0] ir;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r, is_i, is_lw, is_sw, is_br, is_ecall;
  logic       alu_f3_ok, br_f3_ok, r_f7_ok, ill;
  logic       br_taken;
  logic [ALUOP_W-1:0] op_dec;
  logic       unused_bits;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  assign is_r     = (opc == 7'b0110011);
  assign is_i     = (opc == 7'b0010011);
  assign is_lw    = (opc == 7'b0000011);
  assign is_sw    = (opc == 7'b0100011);
  assign is_br    = (opc == 7'b1100011);
  assign is_ecall = (opc == 7'b1110011);

  // 010/011 have no ALU mapping; only SUB may carry funct7 0100000.
  assign alu_f3_ok = (f3 != 3'b010) && (f3 != 3'b011);
  assign br_f3_ok  = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
  assign r_f7_ok   = (f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b000));
  assign ill = !((is_r && alu_f3_ok && r_f7_ok) || (is_i && alu_f3_ok) ||
                 is_lw || is_sw || (is_br && br_f3_ok) || is_ecall);

  // Branch condition from Z (bit 0), N (bit 1) and V (bit 3); C is not needed.
  always_comb begin
    br_taken = 1'b0;
    unique case (f3)
      3'b000:  br_taken = status[0];
      3'b001:  br_taken = !status[0];
      3'b100:  br_taken = status[1] ^ status[3];
      3'b101:  br_taken = !(status[1] ^ status[3]);
      default: br_taken = 1'b0;
    endcase
  end

  // ALU operation for the latched instruction; loads/stores use ADD for address generation.
  always_comb begin
    op_dec = ALU_ADD;
    if (is_r || is_i) begin
      unique case (f3)
        3'b000:  op_dec = (is_r && ir[30]) ? ALU_SUB : ALU_ADD;
        3'b100:  op_dec = ALU_XOR;
        3'b111:  op_dec = ALU_AND;
        3'b110:  op_dec = ALU_OR;
        3'b001:  op_dec = ALU_SL;
        3'b101:  op_dec = ALU_SR;
        default: op_dec = ALU_ADD;
      endcase
    end else if (is_br) begin
      op_dec = ALU_SUB;
    end
  end

  // Register operand fields and C/reserved flags are datapath concerns, not control.
  assign unused_bits = ^{ir[24:15], ir[11:7], status[2], status[STATUS_W-1:4]};

  // Moore output decode; rst forces every output low, and the illegal-NOP WB suppresses regrw.
  always_comb begin
    pcsrc       = 1'b0;
    alusrc      = 1'b0;
    aluop       = '0;
    memrw       = 1'b0;
    wb          = 1'b0;
    regrw       = 1'b0;
    immgen_ctrl = 2'b00;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    state_o     = 3'd0;
    halted      = 1'b0;
    if (!rst) begin
      state_o = state;
      if ((state == ST_EXEC || state == ST_MEM || state == ST_WB) && !ill) begin
        aluop       = op_dec;
        alusrc      = is_i || is_lw || is_sw;
        immgen_ctrl = is_sw ? 2'b01 : (is_br ? 2'b10 : 2'b00);
      end
      unique case (state)
        ST_FETCH: ir_load = 1'b1;
        ST_EXEC: begin
          if (is_br) begin
            pc_write = 1'b1;
            pcsrc    = br_taken;
          end
        end
        ST_MEM: begin
          memrw    = is_sw;
          pc_write = is_sw && !mem_wait;
        end
        ST_WB: begin
          regrw    = !ill;
          wb       = is_lw;
          pc_write = 1'b1;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  // State sequencing, IR latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      ir      <= '0;
      instret <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      if (pc_write) instret <= instret + 1'b1;
      unique case (state)
        ST_FETCH: begin
          ir    <= instr[31:0];
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (is_ecall) begin
            state <= ST_HALT;
          end else if (ill) begin
`ifdef ILLEGAL_TRAP_EN
            state   <= ST_HALT;
            illegal <= 1'b1;
`else
            state <= ST_WB;
`endif
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_br)               state <= ST_FETCH;
          else if (is_lw || is_sw) state <= ST_MEM;
          else                     state <= ST_WB;
        end
        ST_MEM: begin
          if (!mem_wait) state <= is_sw ? ST_FETCH : ST_WB;
        end
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: hand-computed control vectors per FSM cycle.
// Runs a 16-bit-counter instance and a 4-bit-counter instance on the same stimulus.
// Inputs change #1 after the rising edge; outputs are checked in the same window.
module tb_multicycle_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [4:0]  status = '0;
  logic        mem_wait = 1'b0;

  logic        pcsrc, alusrc, memrw, wb, regrw, ir_load, pc_write, halted;
  logic [3:0]  aluop;
  logic [1:0]  immgen_ctrl;
  logic [2:0]  state_o;
  logic [15:0] instret;

  logic        s_pcsrc, s_alusrc, s_memrw, s_wb, s_regrw, s_ir_load, s_pc_write, s_halted;
  logic [3:0]  s_aluop;
  logic [1:0]  s_immgen_ctrl;
  logic [2:0]  s_state_o;
  logic [3:0]  s_instret;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal, s_illegal;
`endif

  multicycle_ctrl_unit #(.XLEN(32), .ALUOP_W(4), .STATUS_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .status(status), .mem_wait(mem_wait),
    .pcsrc(pcsrc), .alusrc(alusrc), .aluop(aluop), .memrw(memrw), .wb(wb), .regrw(regrw),
    .immgen_ctrl(immgen_ctrl), .ir_load(ir_load), .pc_write(pc_write), .state_o(state_o),
    .halted(halted), .instret(instret)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  multicycle_ctrl_unit #(.XLEN(32), .ALUOP_W(4), .STATUS_W(5), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .instr(instr), .status(status), .mem_wait(mem_wait),
    .pcsrc(s_pcsrc), .alusrc(s_alusrc), .aluop(s_aluop), .memrw(s_memrw), .wb(s_wb), .regrw(s_regrw),
    .immgen_ctrl(s_immgen_ctrl), .ir_load(s_ir_load), .pc_write(s_pc_write), .state_o(s_state_o),
    .halted(s_halted), .instret(s_instret)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(s_illegal)
`endif
  );

  logic [13:0] ctl, s_ctl;
  assign ctl   = {pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl, ir_load, pc_write};
  assign s_ctl = {s_pcsrc, s_alusrc, s_aluop, s_memrw, s_wb, s_regrw, s_immgen_ctrl, s_ir_load, s_pc_write};

  localparam logic [31:0] I_ADD   = 32'h003100B3;  // add  x1,x2,x3
  localparam logic [31:0] I_SUB   = 32'h403100B3;  // sub  x1,x2,x3
  localparam logic [31:0] I_XORI  = 32'h00514093;  // xori x1,x2,5
  localparam logic [31:0] I_LW    = 32'h00012083;  // lw   x1,0(x2)
  localparam logic [31:0] I_SW    = 32'h00112223;  // sw   x1,4(x2)
  localparam logic [31:0] I_BEQ   = 32'h00208463;  // beq  x1,x2,8
  localparam logic [31:0] I_BLT   = 32'h0020C463;  // blt  x1,x2,8
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_ECALL = 32'h00000073;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // {pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl, ir_load, pc_write}
  function automatic logic [31:0] cv(input logic pcs, input logic als, input logic [3:0] op,
                                     input logic mrw, input logic w, input logic rrw,
                                     input logic [1:0] imm, input logic irl, input logic pcw);
    return {18'd0, pcs, als, op, mrw, w, rrw, imm, irl, pcw};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ctl", {18'd0, ctl}, 32'd0);
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_instret", {16'd0, instret}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    chk("fetch_ctl", {18'd0, ctl}, cv(0,0,4'h0,0,0,0,2'b00,1,0));

    // SUB then XORI
    instr = I_SUB;
    tick(); chk("sub_dec_ctl", {18'd0, ctl}, 32'd0); chk("sub_dec_st", {29'd0, state_o}, 32'd1);
    tick(); chk("sub_exe_ctl", {18'd0, ctl}, cv(0,0,4'h7,0,0,0,2'b00,0,0)); chk("sub_exe_st", {29'd0, state_o}, 32'd2);
    tick(); chk("sub_wb_ctl",  {18'd0, ctl}, cv(0,0,4'h7,0,0,1,2'b00,0,1)); chk("sub_wb_st", {29'd0, state_o}, 32'd4);
    instr = I_XORI;
    tick(); chk("xori_fetch_ctl", {18'd0, ctl}, cv(0,0,4'h0,0,0,0,2'b00,1,0));
    tick();
    tick(); chk("xori_exe_ctl", {18'd0, ctl}, cv(0,1,4'h1,0,0,0,2'b00,0,0));
    tick(); chk("xori_wb_ctl",  {18'd0, ctl}, cv(0,1,4'h1,0,0,1,2'b00,0,1));
    tick(); chk("alu_instret", {16'd0, instret}, 32'd2); chk("alu_next_st", {29'd0, state_o}, 32'd0);

    // LW with three wait cycles
    instr = I_LW; mem_wait = 1'b1;
    tick();
    tick(); chk("lw_exe_ctl", {18'd0, ctl}, cv(0,1,4'h0,0,0,0,2'b00,0,0));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) mem_wait = 1'b0;
      chk("lw_mem_st", {29'd0, state_o}, 32'd3);
      chk("lw_mem_ctl", {18'd0, ctl}, cv(0,1,4'h0,0,0,0,2'b00,0,0));
    end
    tick(); chk("lw_wb_ctl", {18'd0, ctl}, cv(0,1,4'h0,0,1,1,2'b00,0,1)); chk("lw_wb_st", {29'd0, state_o}, 32'd4);
    tick(); chk("lw_instret", {16'd0, instret}, 32'd3); chk("lw_next_st", {29'd0, state_o}, 32'd0);

    // SW without wait
    instr = I_SW;
    tick();
    tick(); chk("sw_exe_ctl", {18'd0, ctl}, cv(0,1,4'h0,0,0,0,2'b01,0,0));
    tick(); chk("sw_mem_ctl", {18'd0, ctl}, cv(0,1,4'h0,1,0,0,2'b01,0,1)); chk("sw_mem_st", {29'd0, state_o}, 32'd3);
    tick(); chk("sw_instret", {16'd0, instret}, 32'd4); chk("sw_next_st", {29'd0, state_o}, 32'd0);

    // BEQ taken / not taken, BLT taken on N^V
    instr = I_BEQ; status = 5'b00001;
    tick(); tick();
    chk("beq_t_ctl", {18'd0, ctl}, cv(1,0,4'h7,0,0,0,2'b10,0,1));
    tick(); chk("beq_t_st", {29'd0, state_o}, 32'd0); chk("beq_t_instret", {16'd0, instret}, 32'd5);
    status = 5'b00000;
    tick(); tick();
    chk("beq_nt_ctl", {18'd0, ctl}, cv(0,0,4'h7,0,0,0,2'b10,0,1));
    tick(); chk("beq_nt_st", {29'd0, state_o}, 32'd0); chk("beq_nt_instret", {16'd0, instret}, 32'd6);
    instr = I_BLT; status = 5'b00010;
    tick(); tick();
    chk("blt_t_ctl", {18'd0, ctl}, cv(1,0,4'h7,0,0,0,2'b10,0,1));
    tick(); chk("blt_instret", {16'd0, instret}, 32'd7);
    status = 5'b00000;

    // Illegal opcode
    instr = I_ILL;
    tick();
    tick();
`ifdef ILLEGAL_TRAP_EN
    chk("ill_st", {29'd0, state_o}, 32'd5);
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_ctl", {18'd0, ctl}, 32'd0);
    tick();
    chk("ill_instret", {16'd0, instret}, 32'd7);
    chk("ill_flag_small", {31'd0, s_illegal}, 32'd1);
`else
    chk("ill_st", {29'd0, state_o}, 32'd4);
    chk("ill_ctl", {18'd0, ctl}, cv(0,0,4'h0,0,0,0,2'b00,0,1));
    tick();
    chk("ill_next_st", {29'd0, state_o}, 32'd0);
    chk("ill_instret", {16'd0, instret}, 32'd8);
`endif

    // Reset held three cycles starting mid-EXEC of an ADD
    do_reset();
    instr = I_ADD;
    tick(); tick();
    chk("abort_exe_st", {29'd0, state_o}, 32'd2);
    rst = 1'b1;
    #1;
    chk("abort_rst_ctl", {18'd0, ctl}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_regrw", {31'd0, regrw}, 32'd0);
      chk("abort_pcw", {31'd0, pc_write}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("abort_st", {29'd0, state_o}, 32'd0);
    chk("abort_instret", {16'd0, instret}, 32'd0);
    chk("abort_ctl", {18'd0, ctl}, cv(0,0,4'h0,0,0,0,2'b00,1,0));
`ifdef ILLEGAL_TRAP_EN
    chk("abort_ill_clr", {31'd0, illegal}, 32'd0);
`endif

    // 16 ADDs: 4-bit counter wraps to 0, 16-bit counter reaches 16
    for (int k = 0; k < 16; k++) begin
      tick(); tick(); tick();
      chk("wrap_wb_ctl", {18'd0, s_ctl}, cv(0,0,4'h0,0,0,1,2'b00,0,1));
      tick();
      chk("wrap_cnt", {28'd0, s_instret}, 32'((k + 1) & 15));
    end
    chk("wrap_small", {28'd0, s_instret}, 32'd0);
    chk("wrap_big", {16'd0, instret}, 32'd16);

    // ECALL halts and stays halted
    instr = I_ECALL;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_st", {29'd0, s_state_o}, 32'd5);
      chk("halt_flag", {31'd0, s_halted}, 32'd1);
      chk("halt_ctl", {18'd0, ctl}, 32'd0);
      tick();
    end
    chk("halt_st_big", {29'd0, state_o}, 32'd5);
    chk("halt_flag_big", {31'd0, halted}, 32'd1);
    chk("halt_instret", {16'd0, instret}, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
